char_buf_ctrl: RTL

//  Writable 16x16 text buffer (256 cells x 7-bit char code) for the on-screen text layer.

---
 rtl/char_buf_ctrl_pkg.sv | 15 +
 rtl/char_buf_ctrl_if.sv | 27 ++
 rtl/char_buf_ctrl_ram.sv | 33 +++
 rtl/char_buf_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/char_buf_ctrl_pkg.sv
// Shared geometry constants and controller state type for the on-screen text buffer.
// The 16x16 cell grid maps straight onto an 8-bit address: {y, x}.
package vga_pkg;
  localparam int HOR_CHAR_NUMBER = 16;
  localparam int VER_CHAR_NUMBER = 16;
  localparam int CHAR_NUMBER     = HOR_CHAR_NUMBER * VER_CHAR_NUMBER;
  localparam int CHAR_CODE_W     = 7;
  localparam int CHAR_ADDR_W     = 8;

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    WRITE
  } char_buf_state_t;
endpackage

// File: rtl/char_buf_ctrl_if.sv
// Bus bundle between the text buffer and its users: draw-side read port,
// shared requester write port and the clear control/status lines.
interface char_buf_ctrl_if #(
  parameter int N_REQ = 2
);
  import vga_pkg::*;

  logic [CHAR_ADDR_W-1:0]       char_xy;
  logic [CHAR_CODE_W-1:0]       char_code;
  logic [N_REQ-1:0]             wr_req;
  logic [N_REQ*CHAR_ADDR_W-1:0] wr_addr;
  logic [N_REQ*CHAR_CODE_W-1:0] wr_data;
  logic [N_REQ-1:0]             wr_ack;
  logic                         clear_req;
  logic                         busy;
  logic                         clear_done;

  modport master (
    output char_xy, wr_req, wr_addr, wr_data, clear_req,
    input  char_code, wr_ack, busy, clear_done
  );

  modport slave (
    input  char_xy, wr_req, wr_addr, wr_data, clear_req,
    output char_code, wr_ack, busy, clear_done
  );
endinterface

// File: rtl/char_buf_ctrl_ram.sv
// 256x7 simple dual-port RAM: synchronous write, registered read returning
// the pre-write contents when both ports hit the same cell.
module char_ram_16x16
  import vga_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_we,
  input  logic [CHAR_ADDR_W-1:0] i_waddr,
  input  logic [CHAR_CODE_W-1:0] i_wdata,
  input  logic [CHAR_ADDR_W-1:0] i_raddr,
  output logic [CHAR_CODE_W-1:0] o_rdata
);
  logic [CHAR_CODE_W-1:0] r_mem [CHAR_NUMBER];
  logic [CHAR_CODE_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Only the output register is reset; array contents stay un-reset for BRAM inference.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/char_buf_ctrl.sv
// Writable text buffer controller: clear sequencer, round-robin write arbiter
// and the RAM holding the character codes read by the draw pipeline.
module char_buf_ctrl
  import vga_pkg::*;
#(
  parameter int                     N_REQ      = 2,
  parameter logic [CHAR_CODE_W-1:0] CLEAR_CHAR = 7'h20
)(
  input  logic            clk,
  input  logic            rst_n,
  char_buf_ctrl_if.slave  bus
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  char_buf_state_t        r_state;
  char_buf_state_t        w_state_next;
  logic [CHAR_ADDR_W-1:0] r_clr_cnt;
  logic [GW-1:0]          r_last_grant;
  logic                   r_clr_pend;
  logic [N_REQ-1:0]       r_wr_ack;
  logic                   r_clear_done;
  logic [CHAR_ADDR_W-1:0] r_wr_addr;
  logic [CHAR_CODE_W-1:0] r_wr_data;

  logic [GW-1:0]          w_winner;
  logic [GW-1:0]          w_idx;
  logic                   w_any_req;
  logic                   w_grant;
  logic                   w_we;
  logic [CHAR_ADDR_W-1:0] w_waddr;
  logic [CHAR_CODE_W-1:0] w_wdata;
  logic [CHAR_ADDR_W-1:0] w_req_addr [N_REQ];
  logic [CHAR_CODE_W-1:0] w_req_data [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign w_req_addr[gi] = bus.wr_addr[gi*CHAR_ADDR_W +: CHAR_ADDR_W];
    assign w_req_data[gi] = bus.wr_data[gi*CHAR_CODE_W +: CHAR_CODE_W];
  end

  // Scan starts one past the last winner, so every requester is reached within N_REQ grants.
  always_comb begin
    w_any_req = 1'b0;
    w_winner  = r_last_grant;
    w_idx     = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = GW'((int'(r_last_grant) + k) % N_REQ);
      if (!w_any_req && bus.wr_req[w_idx]) begin
        w_any_req = 1'b1;
        w_winner  = w_idx;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_we         = 1'b0;
    w_waddr      = r_clr_cnt;
    w_wdata      = CLEAR_CHAR;
    case (r_state)
      CLEAR: begin
        w_we = 1'b1;
        if (r_clr_cnt == CHAR_ADDR_W'(CHAR_NUMBER - 1)) begin
          w_state_next = IDLE;
        end
      end
      IDLE: begin
        if (r_clr_pend || bus.clear_req) begin
          w_state_next = CLEAR;
        end else if (w_any_req) begin
          w_grant      = 1'b1;
          w_state_next = WRITE;
        end
      end
      WRITE: begin
        w_we         = 1'b1;
        w_waddr      = r_wr_addr;
        w_wdata      = r_wr_data;
        w_state_next = IDLE;
      end
      default: w_state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= CLEAR;
      r_clr_cnt    <= '0;
      r_last_grant <= GW'(N_REQ - 1);
      r_clr_pend   <= 1'b0;
      r_wr_ack     <= '0;
      r_clear_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_clear_done <= (r_state == CLEAR) && (r_clr_cnt == CHAR_ADDR_W'(CHAR_NUMBER - 1));
      if (r_state == CLEAR) begin
        r_clr_cnt <= r_clr_cnt + 1'b1;
      end
      // A clear arriving mid-write is remembered and served once the write has landed.
      if (r_state == WRITE && bus.clear_req) begin
        r_clr_pend <= 1'b1;
      end else if (r_state == IDLE && w_state_next == CLEAR) begin
        r_clr_pend <= 1'b0;
      end
      r_wr_ack <= '0;
      if (w_grant) begin
        r_wr_ack[w_winner] <= 1'b1;
        r_last_grant       <= w_winner;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_grant) begin
      r_wr_addr <= w_req_addr[w_winner];
      r_wr_data <= w_req_data[w_winner];
    end
  end

  char_ram_16x16 u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (bus.char_xy),
    .o_rdata (bus.char_code)
  );

  assign bus.busy       = (r_state == CLEAR);
  assign bus.wr_ack     = r_wr_ack;
  assign bus.clear_done = r_clear_done;
endmodule
